// File: rtl/length_header_checker.sv
// length_header_checker
// Consumes a length-prefixed byte stream. The header (sop) beat carries the
// payload length (0 means 256). The header is stripped, the payload is
// forwarded with its own sop/eop framing one cycle later, and the actual
// payload length is checked against the header.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   din, din_sop, din_eop      input beat, framing qualified by din_vld
//   din_vld                    input valid, no backpressure
//   cnt_clr                    synchronous clear of pkt_cnt / err_cnt
//   dout, dout_sop, dout_eop   forwarded payload beat and framing
//   dout_vld                   payload beat valid
//   err                        one-cycle pulse per framing/length error
//   pkt_cnt, err_cnt           saturating good-packet / error counters
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a header beat; non-sop valid beats are orphans
// ST_PAYLOAD | forwarding payload; a sop here aborts and restarts a packet
module length_header_checker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       din,
   input  logic             din_sop,
   input  logic             din_eop,
   input  logic             din_vld,
   input  logic             cnt_clr,
   output logic [7:0]       dout,
   output logic             dout_sop,
   output logic             dout_eop,
   output logic             dout_vld,
   output logic             err,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_PAYLOAD = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q,    state_d;
   logic [8:0]       exp_len_q,  exp_len_d;
   logic [8:0]       pay_cnt_q,  pay_cnt_d;
   logic [7:0]       dout_q,     dout_d;
   logic             dout_sop_q, dout_sop_d;
   logic             dout_eop_q, dout_eop_d;
   logic             dout_vld_q, dout_vld_d;
   logic             err_q,      err_d;
   logic [CNT_W-1:0] pkt_cnt_q,  pkt_cnt_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

   logic [8:0] hdr_len;
   logic [9:0] pay_cnt_inc;
   logic       pkt_ok;

   // Header value 0 encodes the maximum length of 256.
   assign hdr_len     = (din == 8'd0) ? 9'd256 : {1'b0, din};
   // One bit wider so a saturated count of 511 plus this beat cannot alias.
   assign pay_cnt_inc = {1'b0, pay_cnt_q} + 10'd1;

   always_comb begin
      state_d    = state_q;
      exp_len_d  = exp_len_q;
      pay_cnt_d  = pay_cnt_q;
      dout_d     = dout_q;
      dout_sop_d = 1'b0;
      dout_eop_d = 1'b0;
      dout_vld_d = 1'b0;
      err_d      = 1'b0;
      pkt_ok     = 1'b0;

      if (din_vld) begin
         case (state_q)
            ST_IDLE: begin
               if (din_sop && !din_eop) begin
                  exp_len_d = hdr_len;
                  pay_cnt_d = 9'd0;
                  state_d   = ST_PAYLOAD;
               end else begin
                  // header-only packet or orphan beat
                  err_d = 1'b1;
               end
            end
            ST_PAYLOAD: begin
               if (din_sop) begin
                  // Truncated packet: restart on this header, no eop for the old one.
                  err_d     = 1'b1;
                  exp_len_d = hdr_len;
                  pay_cnt_d = 9'd0;
                  if (din_eop) state_d = ST_IDLE;
               end else begin
                  dout_d     = din;
                  dout_vld_d = 1'b1;
                  dout_sop_d = (pay_cnt_q == 9'd0);
                  dout_eop_d = din_eop;
                  if (pay_cnt_q != 9'h1ff) pay_cnt_d = pay_cnt_q + 9'd1;
                  if (din_eop) begin
                     if (pay_cnt_inc == {1'b0, exp_len_q}) pkt_ok = 1'b1;
                     else                                  err_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (cnt_clr)                          pkt_cnt_d = '0;
      else if (pkt_ok && pkt_cnt_q != '1)   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      else                                  pkt_cnt_d = pkt_cnt_q;

      if (cnt_clr)                          err_cnt_d = '0;
      else if (err_d && err_cnt_q != '1)    err_cnt_d = err_cnt_q + CNT_ONE;
      else                                  err_cnt_d = err_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         exp_len_q  <= '0;
         pay_cnt_q  <= '0;
         dout_q     <= '0;
         dout_sop_q <= 1'b0;
         dout_eop_q <= 1'b0;
         dout_vld_q <= 1'b0;
         err_q      <= 1'b0;
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         exp_len_q  <= exp_len_d;
         pay_cnt_q  <= pay_cnt_d;
         dout_q     <= dout_d;
         dout_sop_q <= dout_sop_d;
         dout_eop_q <= dout_eop_d;
         dout_vld_q <= dout_vld_d;
         err_q      <= err_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign dout     = dout_q;
   assign dout_sop = dout_sop_q;
   assign dout_eop = dout_eop_q;
   assign dout_vld = dout_vld_q;
   assign err      = err_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_length_header_checker.sv
// Bench for length_header_checker. Stimulus is generated at packet level
// (good / bad-length / orphan / header-only / truncated packets, resets,
// random valid gaps and counter clears). Each generated beat is annotated
// with the outputs it must produce one cycle later, derived from the packet
// it belongs to; counters are modelled as true counts clipped to the
// counter range. Two instances run side by side: CNT_W=16 and CNT_W=2.
module tb_length_header_checker;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, din_sop, din_eop, din_vld, cnt_clr;
   logic [7:0] din;

   logic [7:0]  dout,  dout2;
   logic        dout_sop, dout_eop, dout_vld, err;
   logic        dout_sop2, dout_eop2, dout_vld2, err2;
   logic [15:0] pkt_cnt, err_cnt;
   logic [1:0]  pkt_cnt2, err_cnt2;

   length_header_checker #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_sop(din_sop), .din_eop(din_eop),
      .din_vld(din_vld), .cnt_clr(cnt_clr), .dout(dout), .dout_sop(dout_sop),
      .dout_eop(dout_eop), .dout_vld(dout_vld), .err(err),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt));

   length_header_checker #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_sop(din_sop), .din_eop(din_eop),
      .din_vld(din_vld), .cnt_clr(cnt_clr), .dout(dout2), .dout_sop(dout_sop2),
      .dout_eop(dout_eop2), .dout_vld(dout_vld2), .err(err2),
      .pkt_cnt(pkt_cnt2), .err_cnt(err_cnt2));

   typedef struct packed {
      logic       rst, vld, sop, eop, clr;
      logic [7:0] din;
   } beat_t;

   typedef struct packed {
      logic        rst, vld, sop, eop, err;
      logic [7:0]  dout;
      logic [15:0] pkt, errc;
      logic [1:0]  pkt2, errc2;
   } exp_t;

   beat_t bq[$];
   exp_t  eq[$];

   int checks = 0, failures = 0;
   int n_pkt = 0, n_err = 0;
   int gap_pct = 0, clr_pct = 0;
   int cur_beat = 0;
   bit open_pkt = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s beat=%0d got=%0h expected=%0h", tag, cur_beat, obs, expv);
      end
   endtask

   function automatic logic rclr();
      return (int'($urandom_range(0, 99)) < clr_pct);
   endfunction

   function automatic int rand_hdr();
      if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 255));
      return int'($urandom_range(1, 20));
   endfunction

   // Queue one input beat plus the outputs it must produce after the next edge.
   task automatic push(input logic rst, vld, sop, eop, clr, input logic [7:0] d,
                       input logic ov, os, oe, oerr, pinc);
      beat_t b;
      exp_t  e;
      if (rst || clr) begin
         n_pkt = 0;
         n_err = 0;
      end else begin
         n_pkt += int'(pinc);
         n_err += int'(oerr);
      end
      b = '{rst: rst, vld: vld, sop: sop, eop: eop, clr: clr, din: d};
      e = '0;
      e.rst   = rst;
      e.vld   = ov & ~rst;
      e.sop   = os & ~rst;
      e.eop   = oe & ~rst;
      e.err   = oerr & ~rst;
      e.dout  = (ov && !rst) ? d : 8'd0;
      e.pkt   = (n_pkt > 65535) ? 16'hffff : 16'(n_pkt);
      e.errc  = (n_err > 65535) ? 16'hffff : 16'(n_err);
      e.pkt2  = (n_pkt > 3) ? 2'd3 : 2'(n_pkt);
      e.errc2 = (n_err > 3) ? 2'd3 : 2'(n_err);
      bq.push_back(b);
      eq.push_back(e);
   endtask

   task automatic gaps();
      while (int'($urandom_range(0, 99)) < gap_pct)
         push(1'b0, 1'b0, 1'($urandom), 1'($urandom), rclr(), 8'($urandom),
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Header beat; a header arriving while a packet is open aborts it.
   task automatic header(input int hdr);
      gaps();
      push(1'b0, 1'b1, 1'b1, 1'b0, rclr(), 8'(hdr), 1'b0, 1'b0, 1'b0, open_pkt, 1'b0);
      open_pkt = 1'b1;
   endtask

   task automatic packet(input int hdr, input int n, input bit clr_eop);
      int  len;
      bit  last;
      len = (hdr == 0) ? 256 : hdr;
      header(hdr);
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         gaps();
         push(1'b0, 1'b1, 1'b0, last, (last && clr_eop) ? 1'b1 : rclr(), 8'($urandom),
              1'b1, (i == 0), last, last && (n != len), last && (n == len));
      end
      open_pkt = 1'b0;
   endtask

   task automatic partial(input int hdr, input int k);
      header(hdr);
      for (int i = 0; i < k; i++) begin
         gaps();
         push(1'b0, 1'b1, 1'b0, 1'b0, rclr(), 8'($urandom),
              1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic hdr_only();
      gaps();
      push(1'b0, 1'b1, 1'b1, 1'b1, rclr(), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      open_pkt = 1'b0;
   endtask

   task automatic orphan(input logic eop);
      gaps();
      push(1'b0, 1'b1, 1'b0, eop, rclr(), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic reset_beat();
      push(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      open_pkt = 1'b0;
   endtask

   task automatic bad_packet(input int hdr);
      int len, n;
      len = (hdr == 0) ? 256 : hdr;
      n   = int'($urandom_range(1, len + 8));
      if (n == len) n = len + 1;
      packet(hdr, n, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; din = '0; din_sop = 1'b0; din_eop = 1'b0; din_vld = 1'b0; cnt_clr = 1'b0;

      // directed, gap-free
      reset_beat(); reset_beat();
      packet(3, 3, 1'b0);
      packet(4, 3, 1'b0);
      packet(2, 3, 1'b0);
      packet(1, 1, 1'b0);
      packet(0, 256, 1'b0);
      packet(0, 300, 1'b0);
      packet(0, 768, 1'b0);          // would alias to 256 if the beat counter wrapped
      orphan(1'b0);
      hdr_only();
      partial(5, 1);
      packet(5, 5, 1'b0);
      packet(3, 3, 1'b1);            // clear coincident with a matching eop
      packet(2, 2, 1'b0);
      partial(4, 2);
      reset_beat();
      orphan(1'b0); orphan(1'b1);
      packet(2, 2, 1'b0);
      partial(6, 3);
      hdr_only();                    // abort with sop+eop: one error only

      // randomized
      gap_pct = 25;
      clr_pct = 2;
      for (int k = 0; k < 150; k++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (open_pkt && op == 6) op = 5;
         case (op)
            0, 1, 2, 3: begin
               int h;
               h = rand_hdr();
               packet(h, (h == 0) ? 256 : h, 1'b0);
            end
            4, 9: bad_packet(rand_hdr());
            5: hdr_only();
            6: orphan(1'($urandom));
            7: partial(rand_hdr(), int'($urandom_range(0, 4)));
            default: begin
               if ($urandom_range(0, 3) == 0) reset_beat();
               else packet(2, 2, 1'b0);
            end
         endcase
      end

      for (int i = 0; i < bq.size(); i++) begin
         @(negedge clk);
         rst_n   = ~bq[i].rst;
         din     = bq[i].din;
         din_sop = bq[i].sop;
         din_eop = bq[i].eop;
         din_vld = bq[i].vld;
         cnt_clr = bq[i].clr;
         @(posedge clk);
         #1;
         cur_beat = i;
         chk("dout_vld", 32'(dout_vld), 32'(eq[i].vld));
         chk("dout_sop", 32'(dout_sop), 32'(eq[i].sop));
         chk("dout_eop", 32'(dout_eop), 32'(eq[i].eop));
         chk("err",      32'(err),      32'(eq[i].err));
         chk("pkt_cnt",  32'(pkt_cnt),  32'(eq[i].pkt));
         chk("err_cnt",  32'(err_cnt),  32'(eq[i].errc));
         chk("w2_flags", 32'({dout_vld2, dout_sop2, dout_eop2, err2}),
             32'({eq[i].vld, eq[i].sop, eq[i].eop, eq[i].err}));
         chk("w2_pkt_cnt", 32'(pkt_cnt2), 32'(eq[i].pkt2));
         chk("w2_err_cnt", 32'(err_cnt2), 32'(eq[i].errc2));
         if (eq[i].vld || eq[i].rst) begin
            chk("dout",    32'(dout),  32'(eq[i].dout));
            chk("w2_dout", 32'(dout2), 32'(eq[i].dout));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/length_header_checker.md
# length_header_checker

Downstream consumer of the length-prefixed packet stream produced by the message statistics stage. Each packet's first valid beat (`din_sop`) carries an 8-bit payload length, and the remaining beats carry the payload. The block strips the header, forwards the payload with its own sop/eop framing, checks the actual payload length against the header, and keeps saturating good-packet and error counters.

## Interface
- `CNT_W`, 16, width of statistics counters `pkt_cnt` / `err_cnt`

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `din`  in  8  input byte; header (length) on sop beat, payload otherwise
- `din_sop`  in  1  first beat of packet (header beat), qualified by `din_vld`
- `din_eop`  in  1  last beat of packet, qualified by `din_vld`
- `din_vld`  in  1  input beat valid; no backpressure, every valid beat is consumed
- `cnt_clr`  in  1  synchronous clear of `pkt_cnt` and `err_cnt`
- `dout`  out  8  payload byte
- `dout_sop`  out  1  first payload beat
- `dout_eop`  out  1  last payload beat
- `dout_vld`  out  1  payload beat valid
- `err`  out  1  one-cycle pulse per framing/length error
- `pkt_cnt`  out  CNT_W  count of packets whose length matched, saturating
- `err_cnt`  out  CNT_W  count of `err` pulses, saturating

## Operation
- Header decode: `exp_len` (9 bit) = `din` on the sop beat; value 0 means 256, values 1–255 are taken literally.
- Payload counter `pay_cnt` (9 bit): counts forwarded payload beats of the current packet and saturates at 511, so it never wraps to a false match.
- FSM with two states:
  - IDLE: waits for `din_vld & din_sop`.
    - Sop without eop: latch `exp_len`, clear `pay_cnt`, go to PAYLOAD.
    - Sop with eop (header-only packet): `err` pulse, stay in IDLE.
    - Valid beat without sop (orphan): dropped, `err` pulse, stay in IDLE.
  - PAYLOAD: each valid beat is forwarded and `pay_cnt` is incremented.
    - First payload beat after the header gets `dout_sop`=1.
    - Beat with `din_eop`: forwarded with `dout_eop`=1. Compare `pay_cnt+1` against `exp_len`. On match, increment `pkt_cnt`; on mismatch, pulse `err`. Go to IDLE.
    - Beat with `din_sop` (truncated packet, abort): `err` pulse, no `dout_eop` emitted for the aborted packet. The beat is treated as a new header: latch `exp_len`, clear `pay_cnt`, stay in PAYLOAD. If that beat also has `din_eop`, apply the header-only rule and go to IDLE; only one `err` pulse is produced in that cycle.
- Payload is forwarded even when the length is wrong; only `err` marks the packet bad.
- Counters:
  - `err_cnt` increments once per `err` pulse.
  - Both counters saturate at all-ones.
  - `cnt_clr` has priority over an increment in the same cycle; the result is 0.
- Cycles with `din_vld`=0 are ignored in both states, including gaps inside a packet.

## Timing
- All outputs are registered.
- Latency from a `din` beat to its `dout` beat is 1 cycle.
- `err` asserts in the same cycle as the `dout_eop` of the bad packet (length mismatch), or 1 cycle after the offending input beat (orphan, header-only, abort).
- `pkt_cnt` / `err_cnt` update 1 cycle after the beat that decides them, i.e. aligned with `dout_eop` / `err`.
- The header beat produces no output. Back-to-back packets (header immediately after eop) are accepted with no idle cycle.
- Reset (`rst_n`=0 at a clock edge), including mid-packet:
  - FSM goes to IDLE.
  - `dout`=0, `dout_sop`=`dout_eop`=`dout_vld`=`err`=0.
  - `pkt_cnt`=`err_cnt`=0.
  - `exp_len`=`pay_cnt`=0.
  - After reset, the rest of an interrupted packet is treated as orphan beats.

## Test plan
- Good packet: header 0x03, payload A1 A2 A3 (eop on A3), continuous `din_vld`.
  - Output A1(sop), A2, A3(eop), 1 cycle delayed; `err`=0; `pkt_cnt`=1.
- Length mismatch, both directions:
  - Header 0x04 with 3 payload bytes: 3 beats out, `err` pulse with `dout_eop`, `err_cnt`=1, `pkt_cnt` unchanged.
  - Header 0x02 with 3 payload bytes: same response.
- Boundary lengths, back-to-back:
  - Header 0x01 with 1 byte (`dout_sop` and `dout_eop` on the same beat), immediately followed by header 0x00 with 256 bytes.
  - Both packets match; `pkt_cnt`=2.
  - Then 300 bytes after header 0x00: mismatch, `err`=1.
- Framing errors:
  - Orphan beat in IDLE: dropped, `err`.
  - Sop+eop beat: no output, `err`.
  - Sop at the 2nd payload beat of a 5-byte packet: `err`, no `dout_eop`, and the new packet is checked normally.
  - Result: `err_cnt`=3.
- `din_vld` gaps and control:
  - Random `din_vld` gaps inside packets give the same output bytes and counts as the gap-free run.
  - `cnt_clr` asserted together with a matching eop leaves `pkt_cnt`=0.
  - With `CNT_W`=2, the counters saturate at 3.
- Mid-packet reset: assert `rst_n`=0 during payload.
  - All outputs and counters are 0 in the next cycle.
  - Remaining beats are counted as orphans (one `err` each).
  - The next header+payload is forwarded correctly.
